// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The requester drives the master side, serial_adder sits on the slave side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Subtraction is done as A + ~B + 1, so cout=1 means "no borrow".
// Results (sum/cout/ovf) only move on the completing edge and hold otherwise.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:1] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Full adder on the operand LSBs; res_next is the result with this bit
  // shifted in from the MSB side, which is the complete sum on the last bit.
  always_comb begin
    fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    fa_carry = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    res_next = {fa_sum, res[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  // Control FSM plus datapath; on the last bit the carry register still
  // holds the carry into the MSB, which gives the overflow flag directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        RUN: begin
          res   <= res_next[WIDTH-1:1];
          carry <= fa_carry;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum_q  <= res_next;
            cout_q <= fa_carry;
            ovf_q  <= carry ^ fa_carry;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): a vector table, a result
// scoreboard, and hand-written back-to-back and mid-operation reset sequences.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    int           pulseAt;
    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int           checks;
  int           errors;
  exp_t         sbQ[$];
  vec_t         vecs[$];
  logic [W-1:0] prevSum;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    bus.a   = r[W-1:0];
    bus.b   = r[2*W-1:W];
    bus.cin = r[30];
    bus.sub = r[31];
  endtask

  // Runs from just after the accepting edge until done; operands are
  // scrambled every cycle and start may be pulsed or held to probe RUN.
  task automatic waitForDone(input string name, input int expCycles,
                             input int pulseAt, input logic holdStart);
    int   c;
    bit   seen;
    bit   busyOk;
    exp_t e;
    c      = 0;
    seen   = 0;
    busyOk = 1;
    while (!seen && c < W + 4) begin
      c++;
      scramble();
      bus.start = holdStart || (c == pulseAt);
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
      end else begin
        if (!bus.busy) busyOk = 0;
        if (c == 1) checkOutput({name, "_sum_hold"}, bus.sum, prevSum);
      end
    end
    checkOutput({name, "_done_seen"}, seen, 1);
    checkOutput({name, "_latency"}, c, expCycles);
    checkOutput({name, "_busy_in_run"}, busyOk, 1);
    checkOutput({name, "_busy_at_done"}, bus.busy, 0);
    checkOutput({name, "_sb_depth"}, sbQ.size(), 1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({name, "_sum"}, bus.sum, e.sum);
      checkOutput({name, "_cout"}, bus.cout, e.cout);
      checkOutput({name, "_ovf"}, bus.ovf, e.ovf);
      prevSum = e.sum;
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.cin   = v.cin;
    bus.sub   = v.sub;
    e.sum  = v.expSum;
    e.cout = v.expCout;
    e.ovf  = v.expOvf;
    sbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_accept_busy"}, bus.busy, 1);
    waitForDone(name, W, v.pulseAt, 1'b0);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_done_pulse_end"}, bus.done, 0);
    checkOutput({name, "_idle_busy"}, bus.busy, 0);
    checkOutput({name, "_idle_sum_hold"}, bus.sum, prevSum);
  endtask

  initial begin
    exp_t        e;
    vec_t        v;
    logic [31:0] r;
    bit          sawDone;

    checks    = 0;
    errors    = 0;
    prevSum   = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;

    // Reset state.
    #2;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_sum", bus.sum, 0);
    checkOutput("reset_cout", bus.cout, 0);
    checkOutput("reset_ovf", bus.ovf, 0);
    rst = 1'b0;

    // Directed vectors: {a, b, cin, sub, pulseAt, sum, cout, ovf}.
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 0, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h10, 8'h20, 1'b1, 1'b0, 3, 8'h31, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 0, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h03, 8'h04, 1'b1, 1'b1, 0, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h40, 8'h40, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1});
    for (int i = 0; i < 6; i++) begin
      r         = $urandom;
      v.a       = r[7:0];
      v.b       = r[15:8];
      v.cin     = r[16];
      v.sub     = r[17];
      v.pulseAt = 0;
      e         = model(v.a, v.b, v.cin, v.sub);
      v.expSum  = e.sum;
      v.expCout = e.cout;
      v.expOvf  = e.ovf;
      vecs.push_back(v);
    end

    foreach (vecs[i]) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: start held high so the second op is taken on the DONE edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h0F;
    bus.b     = 8'h01;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    sbQ.push_back(model(8'h0F, 8'h01, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_accept_busy", bus.busy, 1);
    waitForDone("b2b_first", W, 0, 1'b1);
    bus.a   = 8'h12;
    bus.b   = 8'h34;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    sbQ.push_back('{8'h46, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_reaccept_busy", bus.busy, 1);
    checkOutput("b2b_reaccept_done", bus.done, 0);
    waitForDone("b2b_second", W, 0, 1'b0);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_done_pulse_end", bus.done, 0);

    // Reset between edges in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h20;
    bus.b     = 8'h03;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", bus.busy, 1);
    checkOutput("pre_reset_sum_hold", bus.sum, prevSum);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_busy", bus.busy, 0);
    checkOutput("rst_async_done", bus.done, 0);
    checkOutput("rst_async_sum", bus.sum, 0);
    checkOutput("rst_async_cout", bus.cout, 0);
    checkOutput("rst_async_ovf", bus.ovf, 0);
    sbQ.delete();
    prevSum = '0;
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    sawDone = 0;
    repeat (W + 3) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) sawDone = 1;
    end
    checkOutput("rst_no_done", sawDone, 0);
    checkOutput("rst_idle_busy", bus.busy, 0);
    checkOutput("rst_sum_stays_zero", bus.sum, 0);

    // Normal operation resumes after reset.
    v = '{8'h21, 8'h21, 1'b0, 1'b0, 0, 8'h42, 1'b0, 1'b0};
    applyStimulus("post_reset", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
